lut_config_loader: RTL and testbench

//  Upstream feeder for the block-configured LUT: accepts a serial/narrow config bitstream,

---
 rtl/lut_config_loader.sv | 139 +++++++++++++
 tb/tb_lut_config_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lut_config_loader.sv
// lut_config_loader: assembles a MEM_SIZE-bit LUT truth table from SHIFT_WIDTH-bit beats
// and commits it to the LUT with a single-cycle config_en/done pulse.
// The first beat lands in the MSBs of config_in.
// Optional feature macro: LUT_CFG_PARITY_EN adds a trailing even-parity beat whose bit 0
// must equal the XOR of all data bits; a mismatch drops the frame and sets a sticky cfg_error.
module lut_config_loader #(
  parameter int unsigned INPUTS      = 4,
  parameter int unsigned MEM_SIZE    = 2**INPUTS,
  parameter int unsigned SHIFT_WIDTH = 1
) (
  input  logic                   config_clk,
  input  logic                   config_rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SHIFT_WIDTH-1:0] bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic                   config_en,
  output logic [MEM_SIZE-1:0]    config_in,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_error
);

  localparam int unsigned Words = MEM_SIZE / SHIFT_WIDTH;
  localparam int unsigned CntW  = $clog2(Words + 1);

  if (MEM_SIZE % SHIFT_WIDTH != 0) begin : gen_bad_shift_width
    $error("MEM_SIZE must be a multiple of SHIFT_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StShift, StParity, StCommit} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [MEM_SIZE-1:0] shift_q, shift_d;
  logic                last_beat;

`ifdef LUT_CFG_PARITY_EN
  logic cfg_error_q, cfg_error_d;
`endif

  assign last_beat = (count_q == CntW'(Words - 1));
  assign busy      = (state_q != StIdle);
  // The LUT only captures on config_en, so exposing the partial shift register is harmless.
  assign config_in = shift_q;

  // Next-state, datapath update and strobe decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    bit_ready = 1'b0;
    config_en = 1'b0;
    done      = 1'b0;
`ifdef LUT_CFG_PARITY_EN
    cfg_error_d = cfg_error_q;
`endif
    unique case (state_q)
      StIdle: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d = StShift;
          count_d = '0;
`ifdef LUT_CFG_PARITY_EN
          cfg_error_d = 1'b0;
`endif
        end
      end
      StShift: begin
        bit_ready = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (bit_valid) begin
          shift_d = (shift_q << SHIFT_WIDTH) | MEM_SIZE'(bit_in);
          count_d = count_q + 1'b1;
          if (last_beat) begin
`ifdef LUT_CFG_PARITY_EN
            state_d = StParity;
`else
            state_d = StCommit;
`endif
          end
        end
      end
`ifdef LUT_CFG_PARITY_EN
      StParity: begin
        bit_ready = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (bit_valid) begin
          // Register holds exactly the MEM_SIZE data bits here, so its XOR is the frame parity.
          if (bit_in[0] == ^shift_q) begin
            state_d = StCommit;
          end else begin
            state_d     = StIdle;
            cfg_error_d = 1'b1;
          end
        end
      end
`endif
      StCommit: begin
        config_en = 1'b1;
        done      = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, beat counter and shift register.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

`ifdef LUT_CFG_PARITY_EN
  // Sticky parity error flag, cleared by an accepted start.
  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      cfg_error_q <= 1'b0;
    end else begin
      cfg_error_q <= cfg_error_d;
    end
  end

  assign cfg_error = cfg_error_q;
`else
  assign cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench for lut_config_loader: the driver pushes every frame that must commit
// (data plus expected commit cycle); an independent monitor pops on each config_en.
// Define LUT_CFG_PARITY_EN for both bench and RTL to exercise the parity beat.
module tb_lut_config_loader;

  localparam int unsigned INPUTS = 4;
  localparam int unsigned MS     = 16;
  localparam int unsigned SW     = 1;
  localparam int unsigned WORDS  = MS / SW;

  logic          config_clk = 1'b0;
  logic          config_rst_n;
  logic          start, abort, bit_valid;
  logic [SW-1:0] bit_in;
  logic          bit_ready, config_en, busy, done, cfg_error;
  logic [MS-1:0] config_in;

  lut_config_loader #(
    .INPUTS      (INPUTS),
    .MEM_SIZE    (MS),
    .SHIFT_WIDTH (SW)
  ) dut (
    .config_clk   (config_clk),
    .config_rst_n (config_rst_n),
    .start        (start),
    .abort        (abort),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .config_en    (config_en),
    .config_in    (config_in),
    .busy         (busy),
    .done         (done),
    .cfg_error    (cfg_error)
  );

  always #5 config_clk = ~config_clk;

  typedef struct {
    logic [MS-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge config_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit must match the oldest outstanding expected frame.
  always @(negedge config_clk) begin
    if (config_rst_n && (config_en || done)) begin
      check("done_with_config_en", done, config_en);
      if (config_en) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_commit: got config_en=1 data %h, expected no commit",
                   config_in);
        end else begin
          mon_e = sb.pop_front();
          check("config_in", config_in, mon_e.data);
          check("commit_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge config_clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge config_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [SW-1:0] b, input logic ab, output logic acc);
    bit_in    = b;
    bit_valid = 1'b1;
    abort     = ab;
    @(negedge config_clk);
    acc = bit_ready;
    @(posedge config_clk);
    #1;
    bit_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bit_ready"}, bit_ready, 0);
    check({tag, "_config_en"}, config_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_error"}, cfg_error, 0);
    check({tag, "_config_in"}, config_in, 0);
  endtask

  // gap: 0 none, 1 one idle cycle between beats, 2 random idles.
  task automatic send_frame(input logic [MS-1:0] data, input int gap, input int abort_at,
                            input int busy_start_at, input bit par_ok);
    logic acc;
    logic pb;
    do_start();
    check("busy_after_start", busy, 1);
    check("cfg_error_clear_on_start", cfg_error, 0);
    for (int i = 0; i < int'(WORDS); i++) begin
      if (gap == 1 && i > 0) idle(1);
      else if (gap == 2) idle($urandom_range(0, 2));
      if (i == busy_start_at) start = 1'b1;
      beat(data[MS-1-i*SW -: SW], (i == abort_at), acc);
      start = 1'b0;
      check("ready_in_shift", acc, 1);
      if (i == abort_at) begin
        check("idle_after_abort", busy, 0);
        return;
      end
    end
`ifdef LUT_CFG_PARITY_EN
    pb = par_ok ? ^data : ~(^data);
    beat(SW'(pb), 1'b0, acc);
    check("ready_in_parity", acc, 1);
    if (!par_ok) begin
      check("cfg_error_set", cfg_error, 1);
      check("idle_after_parity_fail", busy, 0);
      return;
    end
`else
    pb = par_ok;
`endif
    sb.push_back('{data: data, cyc: cyc});
    idle(1);
    check("idle_after_commit", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    config_rst_n = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    bit_valid    = 1'b0;
    bit_in       = '0;
    #12;
    check_zero_outputs("reset");
    config_rst_n = 1'b1;
    idle(2);

    // Beats offered in IDLE must not be consumed.
    bit_in    = '1;
    bit_valid = 1'b1;
    @(negedge config_clk);
    check("ready_low_in_idle", bit_ready, 0);
    idle(2);
    bit_valid = 1'b0;
    check("idle_stays_idle", busy, 0);

    // start together with abort in IDLE: stay idle.
    start = 1'b1;
    abort = 1'b1;
    idle(1);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);

    send_frame(16'hA5C3, 0, -1, -1, 1'b1);
    send_frame(16'hA5C3, 1, -1, -1, 1'b1);
    send_frame(16'h1234, 0, 7, -1, 1'b1);
    send_frame(16'h0001, 0, -1, -1, 1'b1);
    send_frame(16'hBEEF, 0, int'(WORDS) - 1, -1, 1'b1);
    send_frame(16'h5A0F, 0, -1, 5, 1'b1);

    // Reset mid-frame after 10 beats.
    do_start();
    for (int i = 0; i < 10; i++) beat(SW'(i % 2), 1'b0, acc);
    #2;
    config_rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge config_clk);
    config_rst_n = 1'b1;
    idle(1);
    send_frame(16'h8001, 0, -1, -1, 1'b1);

`ifdef LUT_CFG_PARITY_EN
    send_frame(16'hA5C3, 0, -1, -1, 1'b0);
    check("cfg_error_sticky", cfg_error, 1);
    send_frame(16'hA5C3, 0, -1, -1, 1'b1);
`endif

    for (int n = 0; n < 30; n++) begin
      logic [MS-1:0] d;
      int            ab;
      int            bs;
      d  = MS'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
      bs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
      send_frame(d, 2, ab, bs, ($urandom_range(0, 3) != 0));
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("pending_commits", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
